rotation_detector: RTL

Sequential inverse of the 16-bit left/right barrel rotator: given an original word, a rotated word and a direction, it finds the rotation amount that maps one onto the other. It searches one candidate amount per cycle with valid/ready handshakes on both sides. It sits beside the rotator datapath as a self-check and decode unit: the rotator encodes `ctrl` into the data, and this block recovers it.

---
 rtl/rot_pkg.sv | 27 ++
 rtl/rot_step.sv | 18 +
 rtl/rotation_detector.sv | 112 +++++++++++
 3 files changed

// File: rtl/rot_pkg.sv
// Shared definitions for the rotation detector and its rotator neighbours.
//   WIDTH / SHW : data width and rotation-amount width (SHW = log2(WIDTH))
//   state_t     : detector FSM states
//   DIR_RIGHT   : direction encoding, matches the rotator's control polarity
//   rot1()      : single-position rotate, usable as a reference model
package rot_pkg;

  localparam int WIDTH = 16;
  localparam int SHW   = 4;

  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Right by 1: y[i] = word[i+1]; left by 1: y[i] = word[i-1] (indices mod WIDTH).
  function automatic logic [WIDTH-1:0] rot1(input logic [WIDTH-1:0] word, input logic dir);
    if (dir == DIR_RIGHT) begin
      return {word[0], word[WIDTH-1:1]};
    end
    return {word[WIDTH-2:0], word[WIDTH-1]};
  endfunction

endpackage

// File: rtl/rot_step.sv
// Combinational single-position rotate.
//   a   : input word
//   dir : 1 = rotate right, 0 = rotate left
//   y   : a rotated by one position in direction dir
module rot_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic             dir,
  output logic [WIDTH-1:0] y
);
  import rot_pkg::*;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign y[gi] = (dir == DIR_RIGHT) ? a[(gi + 1) % WIDTH] : a[(gi + WIDTH - 1) % WIDTH];
  end

endmodule

// File: rtl/rotation_detector.sv
// Recovers the rotation amount that maps orig onto rotated, testing one
// candidate amount per cycle.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake (orig, rotated, dir)
//   out_valid/out_ready : result handshake (amt, found)
//   amt                 : smallest rotation amount that matches (0 if none)
//   found               : 1 when some rotation matches
module rotation_detector #(
  parameter int WIDTH = rot_pkg::WIDTH,
  parameter int SHW   = rot_pkg::SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] orig,
  input  logic [WIDTH-1:0] rotated,
  input  logic             dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SHW-1:0]   amt,
  output logic             found
);
  import rot_pkg::*;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] tgt_reg;
  logic             d_reg;
  logic [SHW-1:0]   k_reg;
  logic [SHW-1:0]   amt_reg;
  logic             found_reg;
  logic [WIDTH-1:0] work_next;
  logic             match;
  logic             last_k;

  rot_step #(.WIDTH(WIDTH)) u_step (
    .a   (work_reg),
    .dir (d_reg),
    .y   (work_next)
  );

  // Compare is checked before the step, so the first hit is the smallest k.
  assign match  = (work_reg == tgt_reg);
  assign last_k = (k_reg == SHW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)         state_next = SEARCH;
      SEARCH:  if (match || last_k)  state_next = DONE;
      DONE:    if (out_ready)        state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // Datapath: operand latch, candidate counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      work_reg  <= '0;
      tgt_reg   <= '0;
      d_reg     <= 1'b0;
      k_reg     <= '0;
      amt_reg   <= '0;
      found_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            work_reg <= orig;
            tgt_reg  <= rotated;
            d_reg    <= dir;
            k_reg    <= '0;
          end
        end
        SEARCH: begin
          if (match) begin
            amt_reg   <= k_reg;
            found_reg <= 1'b1;
          end else if (last_k) begin
            amt_reg   <= '0;
            found_reg <= 1'b0;
          end else begin
            work_reg <= work_next;
            k_reg    <= k_reg + SHW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: decoded from registered state, result held in registers
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    amt       = amt_reg;
    found     = found_reg;
  end

endmodule
